// File: rtl/mem_port_arbiter.sv
// Arbitrates the unified memory bus between fetch and the MEM stage,
// with alignment checks, byte-lane steering and bus timeout faults.
module mem_port_arbiter #(
  parameter int MAX_MEM_STREAK = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [63:0] if_addr,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_fault,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [1:0]  mem_size,
  input  logic [63:0] mem_addr,
  input  logic [63:0] mem_wdata,
  output logic        mem_rvalid,
  output logic [63:0] mem_rdata,
  output logic        mem_lam,
  output logic        mem_laf,
  output logic        mem_sam,
  output logic        mem_saf,
  output logic        mem_stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [63:0] bus_addr,
  output logic [63:0] bus_wdata,
  output logic [7:0]  bus_wstrb,
  input  logic        bus_rdy,
  input  logic        bus_rvalid,
  input  logic [63:0] bus_rdata,
  input  logic        bus_err
);

  localparam int SW = $clog2(MAX_MEM_STREAK + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ADDR, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   streak_q;
  logic [TW-1:0]   tmo_q;
  logic            own_mem_q;
  logic            we_q;
  logic [1:0]      size_q;
  logic [2:0]      off_q;
  logic            mis_q;
  logic            fault_q;
  logic            bus_we_q;
  logic [63:0]     bus_addr_q;
  logic [63:0]     bus_wdata_q;
  logic [7:0]      bus_wstrb_q;
  logic [31:0]     if_rdata_q;
  logic [63:0]     mem_rdata_q;

  logic            mem_mis;
  logic            if_mis;
  logic            grant_mem;
  logic            grant_if;
  logic            expire;
  logic            rsp;
  logic            resp;
  logic [7:0]      strb_base;
  logic [63:0]     rd_mask;
  logic [63:0]     rd_lane;

  always_comb begin
    mem_mis   = 1'b0;
    strb_base = 8'h01;
    unique case (mem_size)
      2'd0: begin mem_mis = 1'b0;            strb_base = 8'h01; end
      2'd1: begin mem_mis = mem_addr[0];     strb_base = 8'h03; end
      2'd2: begin mem_mis = |mem_addr[1:0];  strb_base = 8'h0f; end
      2'd3: begin mem_mis = |mem_addr[2:0];  strb_base = 8'hff; end
    endcase
  end

  always_comb begin
    rd_mask = 64'hff;
    unique case (size_q)
      2'd0: rd_mask = 64'h0000_0000_0000_00ff;
      2'd1: rd_mask = 64'h0000_0000_0000_ffff;
      2'd2: rd_mask = 64'h0000_0000_ffff_ffff;
      2'd3: rd_mask = 64'hffff_ffff_ffff_ffff;
    endcase
    rd_lane = (bus_rdata >> {off_q, 3'b000}) & rd_mask;
  end

  assign if_mis    = |if_addr[1:0];
  assign grant_mem = mem_req && (!if_req || streak_q < SW'(MAX_MEM_STREAK));
  assign grant_if  = !grant_mem && if_req;
  assign expire    = (tmo_q == TW'(TIMEOUT_CYCLES - 1));
  assign rsp       = (state_q == WAIT) && bus_rvalid;
  assign resp      = (state_q == RESP);

  always_comb begin
    state_d    = state_q;
    bus_req    = 1'b0;
    if_rvalid  = 1'b0;
    if_fault   = 1'b0;
    mem_rvalid = 1'b0;
    mem_lam    = 1'b0;
    mem_laf    = 1'b0;
    mem_sam    = 1'b0;
    mem_saf    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant_mem)     state_d = mem_mis ? RESP : ADDR;
        else if (grant_if) state_d = if_mis ? RESP : ADDR;
      end
      ADDR: begin
        bus_req = 1'b1;
        if (expire)       state_d = RESP;
        else if (bus_rdy) state_d = WAIT;
      end
      WAIT: begin
        if (bus_rvalid || expire) state_d = RESP;
      end
      RESP: begin
        state_d    = IDLE;
        if_rvalid  = !own_mem_q && !fault_q;
        if_fault   = !own_mem_q && fault_q;
        mem_rvalid = own_mem_q && !fault_q;
        mem_lam    = own_mem_q && mis_q && !we_q;
        mem_sam    = own_mem_q && mis_q && we_q;
        mem_laf    = own_mem_q && fault_q && !mis_q && !we_q;
        mem_saf    = own_mem_q && fault_q && !mis_q && we_q;
      end
    endcase
    mem_stall = rst_n && mem_req && !(resp && own_mem_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      streak_q    <= '0;
      tmo_q       <= '0;
      own_mem_q   <= 1'b0;
      we_q        <= 1'b0;
      size_q      <= 2'd0;
      off_q       <= 3'd0;
      mis_q       <= 1'b0;
      fault_q     <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_wstrb_q <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          tmo_q <= '0;
          if (grant_mem) begin
            streak_q    <= if_req ? streak_q + SW'(1) : '0;
            own_mem_q   <= 1'b1;
            we_q        <= mem_we;
            size_q      <= mem_size;
            off_q       <= mem_addr[2:0];
            mis_q       <= mem_mis;
            fault_q     <= mem_mis;
            bus_we_q    <= mem_we;
            bus_addr_q  <= {mem_addr[63:3], 3'b000};
            bus_wdata_q <= mem_we ? mem_wdata << {mem_addr[2:0], 3'b000} : '0;
            bus_wstrb_q <= mem_we ? strb_base << mem_addr[2:0] : '0;
          end else if (grant_if) begin
            streak_q    <= '0;
            own_mem_q   <= 1'b0;
            we_q        <= 1'b0;
            size_q      <= 2'd2;
            off_q       <= if_addr[2:0];
            mis_q       <= if_mis;
            fault_q     <= if_mis;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= {if_addr[63:3], 3'b000};
            bus_wdata_q <= '0;
            bus_wstrb_q <= '0;
          end
        end
        ADDR, WAIT: begin
          tmo_q <= tmo_q + TW'(1);
          if (rsp) begin
            fault_q <= bus_err;
            if (own_mem_q) mem_rdata_q <= rd_lane;
            else if_rdata_q <= off_q[2] ? bus_rdata[63:32] : bus_rdata[31:0];
          end else if (expire) begin
            fault_q <= 1'b1;
          end
        end
        RESP: ;
      endcase
    end
  end

  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_wstrb = bus_wstrb_q;
  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed plan cases plus randomized
// MEM transactions checked against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [63:0] if_addr = '0;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        if_fault;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [1:0]  mem_size = '0;
  logic [63:0] mem_addr = '0;
  logic [63:0] mem_wdata = '0;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;
  logic        mem_lam, mem_laf, mem_sam, mem_saf, mem_stall;
  logic        bus_req, bus_we;
  logic [63:0] bus_addr, bus_wdata;
  logic [7:0]  bus_wstrb;
  logic        bus_rdy = 1'b0;
  logic        bus_rvalid = 1'b0;
  logic [63:0] bus_rdata = '0;
  logic        bus_err = 1'b0;

  int tests = 0;
  int fails = 0;

  mem_port_arbiter #(.MAX_MEM_STREAK(4), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_fault(if_fault),
    .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .mem_lam(mem_lam), .mem_laf(mem_laf),
    .mem_sam(mem_sam), .mem_saf(mem_saf), .mem_stall(mem_stall),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb), .bus_rdy(bus_rdy),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  logic any_out;
  assign any_out = |{if_rvalid, if_rdata, if_fault, mem_rvalid, mem_rdata,
                     mem_lam, mem_laf, mem_sam, mem_saf, mem_stall, bus_req,
                     bus_we, bus_addr, bus_wdata, bus_wstrb};

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] strb_model(input int o, input int nb);
    logic [7:0] s = '0;
    for (int i = 0; i < 8; i++) s[i] = (i >= o) && (i < o + nb);
    return s;
  endfunction

  function automatic logic [63:0] wdata_model(input int o, input logic [63:0] w);
    logic [63:0] r = '0;
    for (int i = 0; i < 8; i++) if (i >= o) r[8*i +: 8] = w[8*(i-o) +: 8];
    return r;
  endfunction

  function automatic logic [63:0] rdata_model(input int o, input int nb,
                                               input logic [63:0] d);
    logic [63:0] r = '0;
    for (int i = 0; i < nb; i++) if (o + i < 8) r[8*i +: 8] = d[8*(o+i) +: 8];
    return r;
  endfunction

  // One MEM transaction; the bus answers on a fixed schedule
  task automatic mem_txn(input string tag, input logic we, input logic [1:0] size,
                         input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [63:0] rdata, input int rdy_lat,
                         input int rv_lat, input logic err);
    int nb = 1 << size;
    int o = int'(addr[2:0]);
    logic mis = (addr % nb) != 0;
    logic normal = (rdy_lat <= T - 2) && (rdy_lat + 1 + rv_lat <= T - 1);
    logic fault;
    int done, last_bus;
    logic [8:0] exp;
    if (mis) begin done = 1; fault = 1'b1; end
    else if (normal) begin done = rdy_lat + rv_lat + 3; fault = err; end
    else begin done = T + 1; fault = 1'b1; end
    last_bus = mis ? 0 : (rdy_lat <= T - 2) ? 1 + rdy_lat : T;
    for (int c = 0; c <= done; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        mem_req = 1'b1; mem_we = we; mem_size = size;
        mem_addr = addr; mem_wdata = wdata;
      end
      bus_rdy    = (c == 1 + rdy_lat);
      bus_rvalid = !mis && (c == 2 + rdy_lat + rv_lat);
      bus_rdata  = rdata;
      bus_err    = err;
      #1;
      exp = {c == done && !fault, c == done && mis && !we,
             c == done && fault && !mis && !we, c == done && mis && we,
             c == done && fault && !mis && we, c < done,
             c >= 1 && c <= last_bus, 2'b00};
      chk({tag, "_ctl"}, {55'b0, mem_rvalid, mem_lam, mem_laf, mem_sam,
          mem_saf, mem_stall, bus_req, if_rvalid, if_fault}, {55'b0, exp});
      if (c == 1 && !mis) begin
        chk({tag, "_addr"}, bus_addr, {addr[63:3], 3'b000});
        chk({tag, "_we"}, {63'b0, bus_we}, {63'b0, we});
        chk({tag, "_strb"}, {56'b0, bus_wstrb}, we ? {56'b0, strb_model(o, nb)} : 64'b0);
        chk({tag, "_wdata"}, bus_wdata, we ? wdata_model(o, wdata) : 64'b0);
      end
      if (c == done && !fault && !we)
        chk({tag, "_rdata"}, mem_rdata, rdata_model(o, nb, rdata));
    end
    mem_req = 1'b0; bus_rdy = 1'b0; bus_rvalid = 1'b0; bus_err = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    string order;
    int done_n;
    logic rvn;
    logic [63:0] cap;
    #2;
    chk("reset_outs", {63'b0, any_out}, 64'b0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    mem_txn("ld_d", 1'b0, 2'd3, 64'h1000, 64'h0, 64'h1122334455667788, 0, 0, 1'b0);
    mem_txn("st_b", 1'b1, 2'd0, 64'h1003, 64'hAB, 64'h0, 1, 1, 1'b0);
    mem_txn("ld_w_mis", 1'b0, 2'd2, 64'h1002, 64'h0, 64'h0, 0, 0, 1'b0);
    mem_txn("st_tmo", 1'b1, 2'd2, 64'h1008, 64'h12345678, 64'h0, 1000, 0, 1'b0);
    mem_txn("after_tmo", 1'b0, 2'd1, 64'h100E, 64'h0, 64'hCAFE_F00D_1234_5678, 0, 1, 1'b0);
    mem_txn("race", 1'b0, 2'd2, 64'h1010, 64'h0, 64'hDEAD_BEEF_0BAD_F00D, 0, T - 2, 1'b0);
    mem_txn("ld_err", 1'b0, 2'd3, 64'h1018, 64'h0, 64'h0, 0, 0, 1'b1);
    mem_txn("st_err", 1'b1, 2'd3, 64'h1020, 64'h55, 64'h0, 2, 0, 1'b1);
    mem_txn("st_mis", 1'b1, 2'd1, 64'h1021, 64'h55, 64'h0, 0, 0, 1'b0);

    for (int k = 0; k < 30; k++)
      mem_txn($sformatf("rnd%0d", k), 1'($urandom_range(0, 1)),
              2'($urandom_range(0, 3)), 64'h2000 + 64'($urandom_range(0, 15)),
              {$urandom, $urandom}, {$urandom, $urandom},
              $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 7) == 0);

    // Both requesters held: MEM wins until the streak limit lets IF in
    rst_n = 1'b0; #2 rst_n = 1'b1;
    if_req = 1'b1; if_addr = 64'h400;
    mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'd3; mem_addr = 64'h3000;
    order = ""; done_n = 0; rvn = 1'b0; cap = '0;
    for (int c = 0; c < 300 && done_n < 10; c++) begin
      @(posedge clk); #1;
      bus_rvalid = rvn;
      rvn = bus_req;
      bus_rdy = bus_req;
      bus_rdata = {$urandom, $urandom};
      if (bus_rvalid) cap = bus_rdata;
      #1;
      if (mem_rvalid) begin
        order = {order, "M"}; done_n++;
        chk("arb_mem_rdata", mem_rdata, cap);
      end
      if (if_rvalid) begin
        order = {order, "I"}; done_n++;
        chk("arb_if_rdata", {32'b0, if_rdata},
            {32'b0, if_addr[2] ? cap[63:32] : cap[31:0]});
        if_addr = if_addr ^ 64'h4;
      end
    end
    tests++;
    assert (order == "MMMMIMMMMI") else begin
      fails++;
      $error("FAIL arb_order: observed %s expected MMMMIMMMMI", order);
    end
    mem_req = 1'b0; if_req = 1'b0; bus_rdy = 1'b0; bus_rvalid = 1'b0;
    repeat (2) @(posedge clk);

    // Misaligned fetch faults without a bus cycle
    #1 if_req = 1'b1; if_addr = 64'h402;
    #1 chk("if_mis_c0", {62'b0, if_fault, bus_req}, 64'b0);
    @(posedge clk); #2;
    chk("if_mis_c1", {62'b0, if_fault, bus_req}, 64'b10);
    if_req = 1'b0;
    @(posedge clk); #2;
    chk("if_mis_c2", {62'b0, if_fault, bus_req}, 64'b0);

    // Reset while waiting for the response
    @(posedge clk); #1;
    mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'd3; mem_addr = 64'h1000;
    @(posedge clk); #1 bus_rdy = 1'b1;
    @(posedge clk); #1 bus_rdy = 1'b0;
    #1 chk("wait_stall", {62'b0, mem_stall, bus_req}, 64'b10);
    rst_n = 1'b0;
    #1 chk("rst_outs", {63'b0, any_out}, 64'b0);
    mem_req = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1 bus_rvalid = 1'b1; bus_rdata = 64'hFFFF;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1 bus_rvalid = 1'b0;
      #1 chk("late_rvalid", {57'b0, mem_rvalid, mem_laf, mem_lam, if_rvalid,
             if_fault, bus_req, mem_stall}, 64'b0);
    end
    mem_txn("post_rst", 1'b1, 2'd2, 64'h1004, 64'h89ABCDEF, 64'h0, 0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
